fb_copy_engine: RTL and testbench

FB_COPY_ENGINE -- requirements
Module: fb_copy_engine

---
 rtl/fb_copy_engine.sv | 124 ++++++++++++
 tb/tb_fb_copy_engine.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_copy_engine.sv
// fb_copy_engine: copies a framebuffer from shared memory into SRAM one word
// at a time. Each word is read, captured, and then written.
// A rising edge on vga_en starts a copy. vga_end pulses for one cycle when
// the last word has been accepted by the SRAM side.
module fb_copy_engine #(
  parameter int DATA_W      = 8,
  parameter int MEM_ADDR_W  = 12,
  parameter int SRAM_ADDR_W = 20,
  parameter int FB_BASE     = 0,
  parameter int FB_WORDS    = 256,
  parameter int SRAM_BASE   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vga_en,
  output logic                   vga_end,
  output logic                   mem_rd_en,
  output logic [MEM_ADDR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0]      mem_rd_data,
  output logic                   copy_en,
  output logic [SRAM_ADDR_W-1:0] copy_addr,
  output logic [DATA_W-1:0]      copy_data,
  input  logic                   copy_ready
);

  // The word index needs at least one bit, even for a one-word framebuffer.
  localparam int IDX_W = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;

  // Base addresses are truncated to the port widths, so address sums wrap
  // naturally at the top of each address space.
  localparam logic [MEM_ADDR_W-1:0]  FB_BASE_A   = MEM_ADDR_W'(FB_BASE);
  localparam logic [SRAM_ADDR_W-1:0] SRAM_BASE_A = SRAM_ADDR_W'(SRAM_BASE);
  localparam logic [IDX_W-1:0]       LAST_IDX    = IDX_W'(FB_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4,
    HOLD = 3'd5
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] data_p0;
  logic              vga_en_p0;

  // The captured word is the SRAM write data. It stays stable through any stall.
  assign copy_data = data_p0;

  // Copy sequencer. Every output is set on the same edge that enters the state
  // it belongs to, so the outputs line up with the state and come straight from
  // registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      data_p0     <= '0;
      vga_en_p0   <= 1'b1;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      copy_en     <= 1'b0;
      copy_addr   <= '0;
      vga_end     <= 1'b0;
    end else begin
      vga_en_p0 <= vga_en;
      case (state)
        IDLE: begin
          // Start only on a real low-to-high transition. A level is not enough.
          if (vga_en && !vga_en_p0) begin
            idx         <= '0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= FB_BASE_A;
            state       <= RD;
          end
        end
        RD: begin
          mem_rd_en <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          data_p0   <= mem_rd_data;
          copy_addr <= SRAM_BASE_A + SRAM_ADDR_W'(idx);
          copy_en   <= 1'b1;
          state     <= WR;
        end
        WR: begin
          // Hold the write request, address and data until the SRAM accepts it.
          if (copy_ready) begin
            copy_en <= 1'b0;
            if (idx == LAST_IDX) begin
              vga_end <= 1'b1;
              state   <= DONE;
            end else begin
              idx         <= idx + IDX_W'(1);
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= FB_BASE_A + MEM_ADDR_W'(idx) + MEM_ADDR_W'(1);
              state       <= RD;
            end
          end
        end
        DONE: begin
          vga_end <= 1'b0;
          state   <= HOLD;
        end
        HOLD: begin
          // Wait here until the request is withdrawn, so a held level cannot
          // start a second copy.
          if (!vga_en) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          mem_rd_en <= 1'b0;
          copy_en   <= 1'b0;
          vga_end   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_copy_engine.sv
// Testbench for fb_copy_engine: a default 256-word instance, a 32-word
// instance whose read window wraps at the top of shared memory, and a
// one-word instance.
module tb_fb_copy_engine;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;

  logic [7:0] mem [0:4095];

  // Default instance
  logic        vga_en, vga_end, mem_rd_en, copy_en, copy_ready;
  logic [11:0] mem_rd_addr;
  logic [7:0]  mem_rd_data, copy_data;
  logic [19:0] copy_addr;

  // Wrapping instance: FB_BASE = 0xFF0, 32 words
  logic        vga_en2, vga_end2, mem_rd_en2, copy_en2;
  logic [11:0] mem_rd_addr2;
  logic [7:0]  mem_rd_data2, copy_data2;
  logic [19:0] copy_addr2;

  // One-word instance
  logic        vga_en3, vga_end3, mem_rd_en3, copy_en3;
  logic [11:0] mem_rd_addr3;
  logic [7:0]  mem_rd_data3, copy_data3;
  logic [19:0] copy_addr3;

  fb_copy_engine dut (
    .clk(clk), .reset(reset), .vga_en(vga_en), .vga_end(vga_end),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .copy_en(copy_en), .copy_addr(copy_addr), .copy_data(copy_data),
    .copy_ready(copy_ready)
  );

  fb_copy_engine #(.FB_BASE(12'hFF0), .FB_WORDS(32)) dut2 (
    .clk(clk), .reset(reset), .vga_en(vga_en2), .vga_end(vga_end2),
    .mem_rd_en(mem_rd_en2), .mem_rd_addr(mem_rd_addr2), .mem_rd_data(mem_rd_data2),
    .copy_en(copy_en2), .copy_addr(copy_addr2), .copy_data(copy_data2),
    .copy_ready(1'b1)
  );

  fb_copy_engine #(.FB_WORDS(1)) dut3 (
    .clk(clk), .reset(reset), .vga_en(vga_en3), .vga_end(vga_end3),
    .mem_rd_en(mem_rd_en3), .mem_rd_addr(mem_rd_addr3), .mem_rd_data(mem_rd_data3),
    .copy_en(copy_en3), .copy_addr(copy_addr3), .copy_data(copy_data3),
    .copy_ready(1'b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Shared memory: the read data is returned one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en)  mem_rd_data  <= mem[mem_rd_addr];
    if (mem_rd_en2) mem_rd_data2 <= mem[mem_rd_addr2];
    if (mem_rd_en3) mem_rd_data3 <= mem[mem_rd_addr3];
  end

  // Observations, sampled on the falling edge
  logic [27:0] wq1[$];
  logic [27:0] wq2[$];
  logic [27:0] wq3[$];
  logic [11:0] rq2[$];
  int end_cnt, end_cyc, rd_cnt, stall_cyc, stall_err;
  int end_cnt2, end_cyc2, end_cnt3, end_cyc3;
  logic        prev_en, prev_rdy;
  logic [19:0] prev_addr;
  logic [7:0]  prev_data;

  always @(negedge clk) begin
    if (copy_en === 1'b1 && copy_ready === 1'b1) wq1.push_back({copy_addr, copy_data});
    if (copy_en === 1'b1 && copy_ready !== 1'b1) stall_cyc++;
    if (vga_end === 1'b1) begin end_cnt++; end_cyc = cyc; end
    if (mem_rd_en === 1'b1) rd_cnt++;
    if (prev_en && !prev_rdy &&
        (copy_en !== 1'b1 || copy_addr !== prev_addr || copy_data !== prev_data)) stall_err++;
    if (mem_rd_en === 1'b1 && copy_en === 1'b1) stall_err++;
    prev_en   = (copy_en === 1'b1);
    prev_rdy  = (copy_ready === 1'b1);
    prev_addr = copy_addr;
    prev_data = copy_data;
    if (copy_en2 === 1'b1) wq2.push_back({copy_addr2, copy_data2});
    if (mem_rd_en2 === 1'b1) rq2.push_back(mem_rd_addr2);
    if (vga_end2 === 1'b1) begin end_cnt2++; end_cyc2 = cyc; end
    if (copy_en3 === 1'b1) wq3.push_back({copy_addr3, copy_data3});
    if (vga_end3 === 1'b1) begin end_cnt3++; end_cyc3 = cyc; end
  end

  logic rand_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) copy_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clear_obs();
    wq1.delete(); wq2.delete(); wq3.delete(); rq2.delete();
    end_cnt = 0; end_cyc = 0; rd_cnt = 0; stall_cyc = 0; stall_err = 0;
    end_cnt2 = 0; end_cyc2 = 0; end_cnt3 = 0; end_cyc3 = 0;
    prev_en = 1'b0; prev_rdy = 1'b1;
  endtask

  task automatic wait_end(input int limit);
    for (int i = 0; i < limit && end_cnt == 0; i++) step();
  endtask

  // Reference: word k lands at SRAM address k carrying shared-memory word k.
  task automatic check_copy(input string tag);
    check({tag, "_nwr"}, wq1.size(), 256);
    for (int k = 0; k < 256 && k < wq1.size(); k++) begin
      check({tag, "_addr"}, {12'd0, wq1[k][27:8]}, k);
      check({tag, "_data"}, {24'd0, wq1[k][7:0]}, {24'd0, mem[k]});
    end
  endtask

  int t0;
  bit found;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    rand_ready = 1'b0;
    copy_ready = 1'b1;
    vga_en = 1'b1; vga_en2 = 1'b0; vga_en3 = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'(a) ^ 8'h5A;
    clear_obs();

    // Reset state, with vga_en already high going into release
    reset = 1'b1;
    #12;
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_copy_en", copy_en, 0);
    check("rst_vga_end", vga_end, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_copy_addr", copy_addr, 0);
    check("rst_copy_data", copy_data, 0);
    step();
    reset = 1'b0;
    clear_obs();
    for (int i = 0; i < 12; i++) step();
    check("rel_high_no_rd", rd_cnt, 0);
    check("rel_high_no_wr", wq1.size(), 0);
    vga_en = 1'b0;
    step();

    // Default copy: single-cycle request, ready tied high
    clear_obs();
    vga_en = 1'b1; t0 = cyc; step(); vga_en = 1'b0;
    wait_end(2000);
    check("basic_end", end_cnt, 1);
    check("basic_time", end_cyc - t0, 769);
    check_copy("basic");
    for (int k = 0; k < 256 && k < wq1.size(); k++)
      check("basic_pattern", {24'd0, wq1[k][7:0]}, {24'd0, 8'(k) ^ 8'h5A});
    for (int i = 0; i < 50; i++) step();
    check("basic_one_end", end_cnt, 1);

    // Random memory contents and random copy_ready, including outside WR
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    clear_obs();
    rand_ready = 1'b1;
    vga_en = 1'b1; t0 = cyc; step(); vga_en = 1'b0;
    wait_end(4000);
    rand_ready = 1'b0; copy_ready = 1'b1;
    check("rand_end", end_cnt, 1);
    check("rand_time", end_cyc - t0, 769 + stall_cyc);
    check("rand_stable", stall_err, 0);
    check_copy("rand");
    for (int i = 0; i < 5; i++) step();

    // Five-cycle stall on word 3
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    clear_obs();
    vga_en = 1'b1; t0 = cyc; step(); vga_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (copy_en === 1'b1 && copy_addr === 20'd3) found = 1'b1;
      else step();
    end
    check("stall_reach_w3", found, 1);
    copy_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    copy_ready = 1'b1;
    wait_end(2000);
    check("stall_end", end_cnt, 1);
    check("stall_time", end_cyc - t0, 774);
    check("stall_cycles", stall_cyc, 5);
    check("stall_stable", stall_err, 0);
    check_copy("stall");
    for (int i = 0; i < 5; i++) step();

    // Level held high for 2000 cycles, then dropped and re-raised
    clear_obs();
    vga_en = 1'b1;
    for (int i = 0; i < 2000; i++) step();
    check("level_end", end_cnt, 1);
    check_copy("level");
    clear_obs();
    vga_en = 1'b0; step(); step();
    vga_en = 1'b1; t0 = cyc;
    wait_end(2000);
    check("rearm_end", end_cnt, 1);
    check("rearm_time", end_cyc - t0, 769);
    check_copy("rearm");
    vga_en = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Second request edge during a copy is ignored
    clear_obs();
    vga_en = 1'b1; step(); vga_en = 1'b0;
    for (int i = 0; i < 100; i++) step();
    vga_en = 1'b1; step(); vga_en = 1'b0;
    wait_end(2000);
    for (int i = 0; i < 1000; i++) step();
    check("dbl_end", end_cnt, 1);
    check_copy("dbl");

    // Reset in the middle of word 100
    clear_obs();
    vga_en = 1'b1; step();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (copy_en === 1'b1 && copy_addr === 20'd100) found = 1'b1;
      else step();
    end
    check("abort_reach_w100", found, 1);
    reset = 1'b1;
    #1;
    check("abort_mem_rd_en", mem_rd_en, 0);
    check("abort_copy_en", copy_en, 0);
    check("abort_vga_end", vga_end, 0);
    check("abort_mem_rd_addr", mem_rd_addr, 0);
    check("abort_copy_addr", copy_addr, 0);
    check("abort_copy_data", copy_data, 0);
    step(); step();
    reset = 1'b0;
    clear_obs();
    for (int i = 0; i < 20; i++) step();
    check("abort_no_end", end_cnt, 0);
    check("abort_no_rd", rd_cnt, 0);
    check("abort_no_wr", wq1.size(), 0);
    vga_en = 1'b0; step();
    vga_en = 1'b1; t0 = cyc;
    wait_end(2000);
    check("abort_restart_end", end_cnt, 1);
    check("abort_restart_time", end_cyc - t0, 769);
    check_copy("abort_restart");
    vga_en = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Framebuffer window that wraps past the top of shared memory
    clear_obs();
    vga_en2 = 1'b1; t0 = cyc; step(); vga_en2 = 1'b0;
    for (int i = 0; i < 500 && end_cnt2 == 0; i++) step();
    check("wrap_end", end_cnt2, 1);
    check("wrap_time", end_cyc2 - t0, 97);
    check("wrap_nrd", rq2.size(), 32);
    check("wrap_nwr", wq2.size(), 32);
    for (int k = 0; k < 32 && k < rq2.size() && k < wq2.size(); k++) begin
      check("wrap_rd_addr", {20'd0, rq2[k]}, (12'hFF0 + k) % 4096);
      check("wrap_addr", {12'd0, wq2[k][27:8]}, k);
      check("wrap_data", {24'd0, wq2[k][7:0]}, {24'd0, mem[(12'hFF0 + k) % 4096]});
    end

    // One-word framebuffer
    clear_obs();
    vga_en3 = 1'b1; t0 = cyc; step(); vga_en3 = 1'b0;
    for (int i = 0; i < 50 && end_cnt3 == 0; i++) step();
    for (int i = 0; i < 10; i++) step();
    check("one_end", end_cnt3, 1);
    check("one_time", end_cyc3 - t0, 4);
    check("one_nwr", wq3.size(), 1);
    if (wq3.size() > 0) begin
      check("one_addr", {12'd0, wq3[0][27:8]}, 0);
      check("one_data", {24'd0, wq3[0][7:0]}, {24'd0, mem[0]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
